// File: rtl/piso_stream.sv
// Parallel-in serial-out shifter with valid/ready load, per-word bit order and done/busy status.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             lsb_first,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int L = WIDTH + 1;
`else
  localparam int L = WIDTH;
`endif
  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic             order;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             emit;
  logic             last;
  logic             next_bit;
`ifdef PISO_PARITY_EN
  logic             parity;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A new word may be accepted on the very edge that emits the last bit.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    emit       = 1'b0;
    last       = (cnt == LAST);
    case (state)
      IDLE:  in_ready = 1'b1;
      SHIFT: begin
        emit     = shift_en;
        in_ready = shift_en && last;
      end
      default: state_next = IDLE;
    endcase
    if (!rst_n) in_ready = 1'b0;
    load = in_valid && in_ready;
    if (load)              state_next = SHIFT;
    else if (emit && last) state_next = IDLE;
  end

  always_comb begin
    next_bit = order ? shreg[0] : shreg[WIDTH-1];
`ifdef PISO_PARITY_EN
    if (cnt == CW'(WIDTH)) next_bit = parity;
`endif
  end

  // Load overrides the shift/count update when both happen on one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg        <= '0;
      order        <= 1'b0;
      cnt          <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef PISO_PARITY_EN
      parity       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (emit) begin
        serial_out   <= next_bit;
        serial_valid <= 1'b1;
        shreg        <= order ? (shreg >> 1) : (shreg << 1);
        cnt          <= last ? '0 : cnt + 1'b1;
        if (last) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
      end else if (state == IDLE && shift_en && !load) begin
        serial_out   <= 1'b0;
        serial_valid <= 1'b0;
      end
      if (load) begin
        shreg <= parallel_in;
        order <= lsb_first;
        cnt   <= '0;
        busy  <= 1'b1;
`ifdef PISO_PARITY_EN
        parity <= ^parallel_in;
`endif
      end
    end
  end

endmodule

// File: doc/piso_stream.md
# piso_stream

Parametrised parallel-in serial-out shifter with a valid/ready load handshake, run-time bit-order select, frame counting and back-to-back frame streaming. Sits between a word-oriented producer and a bit-serial transmit line. A bit-rate strobe (`shift_en`) paces output. `busy`/`done` status lets a controller sequence frames without external counters.

## Interface
- `WIDTH`, 8, data word width in bits, ≥2
- `clk`  in  1  clock, all activity on rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `parallel_in`  in  WIDTH  word to serialise
- `in_valid`  in  1  producer offers `parallel_in`
- `in_ready`  out  1  block accepts word this cycle (combinational)
- `lsb_first`  in  1  bit order for the offered word: 1 = LSB first, 0 = MSB first
- `shift_en`  in  1  bit-rate strobe, one bit emitted per high cycle
- `serial_out`  out  1  current serial bit (registered)
- `serial_valid`  out  1  `serial_out` holds a frame bit (registered)
- `busy`  out  1  frame loaded and not yet fully emitted
- `done`  out  1  one-cycle pulse on the edge that emits a frame's last bit

## Operation
- Reset (`rst_n`=0 at a rising edge): state IDLE, shift register 0, bit counter 0; `serial_out`=0, `serial_valid`=0, `busy`=0, `done`=0.
- While `rst_n`=0, `in_ready` is forced to 0.
- A handshake completes when `in_valid` && `in_ready`. The word and `lsb_first` are captured on that edge and the state moves to SHIFT.
- Frame length L = WIDTH, or WIDTH+1 with parity (see Configuration).
- States:
  - IDLE → SHIFT on handshake.
  - SHIFT → IDLE on the edge that emits bit L-1 with no handshake.
  - SHIFT → SHIFT on the same edge if a handshake occurs (back-to-back).
- `in_ready` = IDLE, or (SHIFT && `shift_en` && emitting bit L-1).
- In SHIFT, on a `shift_en`=1 edge:
  - `serial_out` ← next bit in the captured order.
  - `serial_valid` ← 1.
  - Counter increments.
- In SHIFT, on a `shift_en`=0 edge, all outputs hold.
- In IDLE, on a `shift_en`=1 edge: `serial_out` ← 0 and `serial_valid` ← 0. The last bit of the previous frame is held for exactly one full bit period.
- If a handshake occurs in IDLE on a `shift_en`=1 cycle, the load takes priority and no bit is emitted that edge.
- `busy` is registered: 1 from the accept edge until the edge that emits bit L-1 with no new handshake.
- Counter range is 0..L-1, width $clog2(L+1). No wrap beyond L-1.
- `parallel_in`/`lsb_first` changes while not handshaking have no effect.
- Reset mid-frame aborts the frame immediately: no `done` and no further bits.

## Timing
- Accept at edge E0. The first bit appears after the first `shift_en` edge strictly after E0.
- With `shift_en` continuously high: the first bit appears at E0+1, and bit k appears at E0+1+k.
- `done` is high for the single cycle following the edge that emits bit L-1.
- Back-to-back with `shift_en` continuously high: there are no idle bit slots between frames, and `serial_valid` stays high.
- `in_ready` is combinational from state, counter and `shift_en`. It has no dependence on `in_valid`.

## Configuration
- `PISO_PARITY_EN` defined:
  - L = WIDTH+1.
  - After the data bits, an even-parity bit (XOR of the captured word) is emitted.
  - `done` pulses on the edge that emits the parity bit.
- `PISO_PARITY_EN` undefined:
  - L = WIDTH.
  - No parity logic is present.

## Test plan
- Reset then idle: `rst_n`=0 for 2 cycles with `in_valid`=1 → `in_ready`=0 and all outputs 0. After release, `in_ready`=1 and no word is accepted during reset.
- MSB-first, WIDTH=8, word 8'hA5, `lsb_first`=0, `shift_en` always 1 → `serial_out` = 1,0,1,0,0,1,0,1 on cycles E0+1..E0+8. `done` high in the cycle after E0+8. `busy` deasserts at E0+8.
- LSB-first with `shift_en` every 3rd cycle, word 8'h81 → bits 1,0,0,0,0,0,0,1, each held 3 cycles. `serial_valid`=1 throughout.
- Back-to-back: 8'hF0 (MSB-first) then 8'h0F (LSB-first) offered continuously → 16 contiguous bits 1111_0000_1111_0000. Second accept occurs on the first frame's last-bit edge. `done` pulses twice, 8 cycles apart.
- Reset mid-frame after 3 bits of 8'hFF → next cycle all outputs 0, no `done`, `in_ready`=1 after release.
- With `PISO_PARITY_EN`, word 8'h07 → 9 bits ending in parity 1. `done` follows the 9th bit.
